// File: rtl/microcode_sequencer.sv
// Microcode sequencer: accepts one instruction per handshake and walks its
// micro-steps, driving register-file, ALU and output-latch strobes.
module microcode_sequencer #(
  parameter int NSTEP_W = 2
) (
  input  logic       clk,
  input  logic       grst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [3:0] imm,
  output logic       a_lrst,
  output logic       a_rs1,
  output logic       a_rs2,
  output logic       a_ws1,
  output logic       b_lrst,
  output logic       b_rs1,
  output logic       b_rs2,
  output logic       b_ws1,
  output logic       alu_lda,
  output logic       alu_ldb,
  output logic [1:0] alu_op,
  output logic       alu_ws,
  output logic       out_rs,
  output logic       halted
);

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_LDB   = 4'h2;
  localparam logic [3:0] OP_MOVAB = 4'h3;
  localparam logic [3:0] OP_MOVBA = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_OR    = 4'h8;
  localparam logic [3:0] OP_OUTA  = 4'h9;
  localparam logic [3:0] OP_OUTB  = 4'hA;
  localparam logic [3:0] OP_CLRA  = 4'hB;
  localparam logic [3:0] OP_CLRB  = 4'hC;
  localparam logic [3:0] OP_HLT   = 4'hF;

  state_t             state;
  logic [7:0]         ir;
  logic [NSTEP_W-1:0] step;
  logic [3:0]         opc;

  assign opc = ir[7:4];

  // ALU instructions take three steps; every other opcode (including the
  // undefined ones) finishes in a single step.
  function automatic logic [NSTEP_W-1:0] last_step(input logic [3:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR)
      last_step = NSTEP_W'(2);
    else
      last_step = '0;
  endfunction

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      state <= IDLE;
      ir    <= '0;
      step  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            step  <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (step == last_step(opc)) begin
            step  <= '0;
            state <= (opc == OP_HLT) ? HALT : IDLE;
          end else begin
            step <= step + 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign halted      = (state == HALT);
  assign imm         = ir[3:0];

  // Strobes come only from the registered IR/step, so an async reset of
  // those registers silences the bus within the same cycle.
  always_comb begin
    a_lrst  = 1'b0;
    a_rs1   = 1'b0;
    a_rs2   = 1'b0;
    a_ws1   = 1'b0;
    b_lrst  = 1'b0;
    b_rs1   = 1'b0;
    b_rs2   = 1'b0;
    b_ws1   = 1'b0;
    alu_lda = 1'b0;
    alu_ldb = 1'b0;
    alu_ws  = 1'b0;
    out_rs  = 1'b0;
    alu_op  = 2'b00;
    if (state == EXEC) begin
      case (opc)
        OP_LDA:   a_rs1 = 1'b1;
        OP_LDB:   b_rs1 = 1'b1;
        OP_MOVAB: begin
          a_ws1 = 1'b1;
          b_rs2 = 1'b1;
        end
        OP_MOVBA: begin
          b_ws1 = 1'b1;
          a_rs2 = 1'b1;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          alu_op = 2'(opc - OP_ADD);
          case (step)
            NSTEP_W'(0): begin
              a_ws1   = 1'b1;
              alu_lda = 1'b1;
            end
            NSTEP_W'(1): begin
              b_ws1   = 1'b1;
              alu_ldb = 1'b1;
            end
            NSTEP_W'(2): begin
              alu_ws = 1'b1;
              a_rs2  = 1'b1;
            end
            default: ;
          endcase
        end
        OP_OUTA: begin
          a_ws1  = 1'b1;
          out_rs = 1'b1;
        end
        OP_OUTB: begin
          b_ws1  = 1'b1;
          out_rs = 1'b1;
        end
        OP_CLRA: a_lrst = 1'b1;
        OP_CLRB: b_lrst = 1'b1;
        OP_NOP, OP_HLT: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed + random bench for microcode_sequencer: per-cycle expected output
// vectors are queued at issue time and popped one per clock.
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       grst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] imm;
  logic       a_lrst, a_rs1, a_rs2, a_ws1;
  logic       b_lrst, b_rs1, b_rs2, b_ws1;
  logic       alu_lda, alu_ldb, alu_ws, out_rs, halted;
  logic [1:0] alu_op;

  microcode_sequencer #(.NSTEP_W(2)) dut (
    .clk(clk), .grst(grst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .imm(imm),
    .a_lrst(a_lrst), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_ws1(a_ws1),
    .b_lrst(b_lrst), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_ws1(b_ws1),
    .alu_lda(alu_lda), .alu_ldb(alu_ldb), .alu_op(alu_op), .alu_ws(alu_ws),
    .out_rs(out_rs), .halted(halted)
  );

  always #5 clk = ~clk;

  // Strobe bit positions within the 12-bit strobe field.
  localparam logic [11:0] S_ALRST = 12'h800, S_ARS1 = 12'h400, S_ARS2 = 12'h200, S_AWS1 = 12'h100;
  localparam logic [11:0] S_BLRST = 12'h080, S_BRS1 = 12'h040, S_BRS2 = 12'h020, S_BWS1 = 12'h010;
  localparam logic [11:0] S_LDA = 12'h008, S_LDB = 12'h004, S_ALUWS = 12'h002, S_OUTRS = 12'h001;
  localparam logic [19:0] M_ALL   = 20'hFFFFF;
  localparam logic [19:0] M_NORDY = 20'h7FFFF;

  int n_chk  = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  assign obs = {instr_ready, halted, imm, alu_op,
                a_lrst, a_rs1, a_rs2, a_ws1, b_lrst, b_rs1, b_rs2, b_ws1,
                alu_lda, alu_ldb, alu_ws, out_rs};

  function automatic logic [19:0] mk(input logic rdy, input logic hlt, input logic [3:0] im,
                                     input logic [1:0] op, input logic [11:0] st);
    mk = {rdy, hlt, im, op, st};
  endfunction

  function automatic int nsteps(input logic [3:0] op);
    nsteps = (op >= 4'h5 && op <= 4'h8) ? 3 : 1;
  endfunction

  function automatic logic [1:0] aluop_exp(input logic [3:0] op);
    case (op)
      4'h5: aluop_exp = 2'b00;
      4'h6: aluop_exp = 2'b01;
      4'h7: aluop_exp = 2'b10;
      4'h8: aluop_exp = 2'b11;
      default: aluop_exp = 2'b00;
    endcase
  endfunction

  function automatic logic [11:0] strobe_exp(input logic [3:0] op, input int s);
    strobe_exp = 12'h000;
    case (op)
      4'h1: strobe_exp = S_ARS1;
      4'h2: strobe_exp = S_BRS1;
      4'h3: strobe_exp = S_AWS1 | S_BRS2;
      4'h4: strobe_exp = S_BWS1 | S_ARS2;
      4'h5, 4'h6, 4'h7, 4'h8:
        strobe_exp = (s == 0) ? (S_AWS1 | S_LDA) :
                     (s == 1) ? (S_BWS1 | S_LDB) : (S_ALUWS | S_ARS2);
      4'h9: strobe_exp = S_AWS1 | S_OUTRS;
      4'hA: strobe_exp = S_BWS1 | S_OUTRS;
      4'hB: strobe_exp = S_ALRST;
      4'hC: strobe_exp = S_BLRST;
      default: strobe_exp = 12'h000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] want,
                     input logic [19:0] mask);
    n_chk++;
    assert ((got & mask) === (want & mask)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got & mask, want & mask);
    end
  endtask

  task automatic step_chk(input string tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, exp_q.pop_front(), M_ALL);
    end
  endtask

  // Issue one instruction from IDLE; during EXEC a junk word is held valid
  // and must be ignored. Returns just after the following IDLE/HALT cycle check.
  task automatic run_instr(input logic [7:0] x);
    int n;
    string tag;
    n   = nsteps(x[7:4]);
    tag = $sformatf("instr_%h", x);
    instr       = x;
    instr_valid = 1'b1;
    for (int s = 0; s < n; s++)
      exp_q.push_back(mk(1'b0, 1'b0, x[3:0], aluop_exp(x[7:4]), strobe_exp(x[7:4], s)));
    if (x[7:4] == 4'hF)
      exp_q.push_back(mk(1'b0, 1'b1, x[3:0], 2'b00, 12'h000));
    else
      exp_q.push_back(mk(1'b1, 1'b0, x[3:0], 2'b00, 12'h000));
    step_chk(tag);
    instr       = 8'hB7;
    instr_valid = 1'b1;
    for (int s = 0; s < n; s++)
      step_chk(tag);
    instr_valid = 1'b0;
  endtask

  // Bus-driver and per-register strobe exclusivity, every cycle.
  always @(negedge clk) begin
    n_chk++;
    assert ($countones({a_ws1, b_ws1, alu_ws}) <= 1 &&
            $countones({a_lrst, a_rs1, a_rs2}) <= 1 &&
            $countones({b_lrst, b_rs1, b_rs2}) <= 1) else begin
      n_fail++;
      $error("FAIL invariant: observed drivers %b a %b b %b expected at most one each",
             {a_ws1, b_ws1, alu_ws}, {a_lrst, a_rs1, a_rs2}, {b_lrst, b_rs1, b_rs2});
    end
  end

  initial begin
    logic [7:0] dirs [$];
    grst        = 1'b1;
    instr       = 8'h15;
    instr_valid = 1'b1;

    // Reset held with a valid word waiting: nothing may be driven.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset", obs, mk(1'b0, 1'b0, 4'h0, 2'b00, 12'h000), M_NORDY);
    end
    grst = 1'b0;

    // First edge after reset release captures LDA 5.
    run_instr(8'h15);
    run_instr(8'h50);

    // LDA 3, LDB 2, SUB, OUTA streamed back to back.
    run_instr(8'h13);
    run_instr(8'h22);
    run_instr(8'h60);
    run_instr(8'h90);

    dirs = '{8'h00, 8'h3A, 8'h41, 8'h7F, 8'h86, 8'hA2, 8'hB9, 8'hC4, 8'hD1, 8'hE8};
    foreach (dirs[i]) run_instr(dirs[i]);

    repeat (40) run_instr({4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))});

    // Abort OR during its second step with an asynchronous reset.
    instr       = 8'h8A;
    instr_valid = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 4'hA, 2'b11, S_AWS1 | S_LDA));
    exp_q.push_back(mk(1'b0, 1'b0, 4'hA, 2'b11, S_BWS1 | S_LDB));
    step_chk("or_s0");
    instr_valid = 1'b0;
    step_chk("or_s1");
    #2 grst = 1'b1;
    #1 chk("abort_async", obs, mk(1'b0, 1'b0, 4'h0, 2'b00, 12'h000), M_NORDY);
    @(posedge clk);
    #1 chk("abort_held", obs, mk(1'b0, 1'b0, 4'h0, 2'b00, 12'h000), M_NORDY);
    grst = 1'b0;
    repeat (3) begin
      exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 2'b00, 12'h000));
      step_chk("after_abort");
    end

    // HLT, then a valid word held: stays halted until reset.
    run_instr(8'hF0);
    instr       = 8'h15;
    instr_valid = 1'b1;
    repeat (5) begin
      exp_q.push_back(mk(1'b0, 1'b1, 4'h0, 2'b00, 12'h000));
      step_chk("halted");
    end
    instr_valid = 1'b0;
    #2 grst = 1'b1;
    #2 grst = 1'b0;
    #1 chk("halt_reset", obs, mk(1'b1, 1'b0, 4'h0, 2'b00, 12'h000), M_ALL);
    exp_q.push_back(mk(1'b1, 1'b0, 4'h0, 2'b00, 12'h000));
    step_chk("idle_after_halt");
    run_instr(8'h9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Control stage directly upstream of the register file.
- Accepts one 8-bit instruction per handshake: opcode in instr[7:4], immediate in instr[3:0].
- Steps through that instruction's micro-steps, one per clock, and drives the per-register tristate/load/clear strobes for registers A and B, the ALU and the output latch.
- Owns bus arbitration: at most one bus driver is enabled in any cycle.

Parameters:
- NSTEP_W, 2, width of the micro-step counter (maximum 4 steps per instruction).

Ports:
- clk  input  1  system clock, rising edge.
- grst  input  1  global reset, asynchronous, active-high.
- instr  input  8  instruction word; [7:4] opcode, [3:0] immediate.
- instr_valid  input  1  upstream presents a valid instr.
- instr_ready  output  1  sequencer can accept an instruction this cycle.
- imm  output  4  immediate of the current instruction, to the register file.
- a_lrst, a_rs1, a_rs2, a_ws1  output  1 each  register A: local clear, load imm, load bus, drive bus.
- b_lrst, b_rs1, b_rs2, b_ws1  output  1 each  register B: same meanings.
- alu_lda, alu_ldb  output  1 each  ALU latches its operand A/B from the bus.
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_ws  output  1  ALU drives its result onto the bus.
- out_rs  output  1  output latch loads from the bus.
- halted  output  1  HLT executed.

Behaviour:
- Reset (grst high, async):
  - State is IDLE, IR=0x00, step=0.
  - All strobes are 0, alu_op=00, imm=0, halted=0.
  - instr_ready is 1 once grst deasserts.
  - Reset in any state, including mid-instruction, aborts the instruction immediately with no further strobes.
- States: IDLE, EXEC, HALT.
- IDLE:
  - instr_ready=1, all strobes 0.
  - instr_valid&&instr_ready at a rising edge: IR<=instr, step<=0, go to EXEC.
- EXEC:
  - instr_ready=0.
  - Strobes are decoded only from the registered IR and step, never from the instr input.
  - step increments each cycle.
  - On the last step of the opcode, next state is IDLE (or HALT for HLT).
- imm = IR[3:0] at all times, held stable through EXEC.
- Micro-programs, listed per step (S0, S1, S2):
  - 0 NOP: S0 none.
  - 1 LDA: S0 a_rs1.
  - 2 LDB: S0 b_rs1.
  - 3 MOVAB: S0 a_ws1+b_rs2.
  - 4 MOVBA: S0 b_ws1+a_rs2.
  - 5 ADD, 6 SUB, 7 AND, 8 OR: S0 a_ws1+alu_lda; S1 b_ws1+alu_ldb; S2 alu_ws+a_rs2.
    - alu_op = opcode-5 during all three steps.
  - 9 OUTA: S0 a_ws1+out_rs.
  - A OUTB: S0 b_ws1+out_rs.
  - B CLRA: S0 a_lrst.
  - C CLRB: S0 b_lrst.
  - F HLT: S0 none, then HALT.
  - D, E: undefined, executed as NOP (1 step).
- HALT: instr_ready=0, halted=1, all strobes 0. Only grst leaves HALT.
- Latency:
  - Instruction accepted at edge k.
  - S0 strobes are valid during cycle k+1.
  - Next acceptance occurs n+1 edges later, where n is the step count.
  - Throughput is one instruction per n+1 cycles.
- Invariant: at most one of {a_ws1, b_ws1, alu_ws} is high in any cycle.
- Invariant: at most one of each register's {lrst, rs1, rs2} is high in any cycle.
- instr_valid held while instr_ready=0 is ignored; upstream must hold the word until accepted.
- instr_valid deasserting in the same cycle as acceptance has no effect; the captured IR is used.

Test Plan:
- Reset with instr_valid=1 -> all strobes 0, halted=0; first edge after grst deassert captures the instruction.
- LDA 0x5 (0x15) -> next cycle a_rs1=1, imm=5 for exactly 1 cycle; instr_ready returns to 1 the cycle after.
- ADD (0x50) -> three consecutive cycles: (a_ws1,alu_lda), (b_ws1,alu_ldb), (alu_ws,a_rs2) with alu_op=00 throughout; instr_ready low for exactly 3 cycles.
- Program LDA 3, LDB 2, SUB, OUTA streamed with instr_valid always high -> accept spacing 2,2,4,2 cycles; alu_op=01 during SUB; out_rs coincides with a_ws1.
- HLT (0xF0) then instr_valid held high -> halted=1, instr_ready=0 indefinitely, no strobes; grst pulse returns to IDLE with halted=0.
- grst asserted asynchronously during S1 of OR (0x80) -> strobes drop to 0 before the next edge; the aborted instruction is not resumed; every-cycle checker confirms the single-bus-driver invariant over random legal opcode streams.
